// File: rtl/ddram_arbiter.sv
// Two-requester arbiter for the shared MiSTer DDRAM Avalon-MM port; grants per burst.
// Optional macro JTAGDEMO_DDRARB_FIXEDPRIO_EN: port 0 always wins ties instead of round-robin.
module ddram_arbiter #(
    parameter int ADDR_W  = 29,
    parameter int BURST_W = 8
) (
    input  logic               clk,
    input  logic               reset_in,
    input  logic [ADDR_W-1:0]  rq0_addr,
    input  logic [BURST_W-1:0] rq0_burstcnt,
    input  logic               rq0_rd,
    input  logic               rq0_we,
    input  logic [63:0]        rq0_din,
    input  logic [7:0]         rq0_be,
    output logic               rq0_busy,
    output logic [63:0]        rq0_dout,
    output logic               rq0_dout_ready,
    input  logic [ADDR_W-1:0]  rq1_addr,
    input  logic [BURST_W-1:0] rq1_burstcnt,
    input  logic               rq1_rd,
    input  logic               rq1_we,
    input  logic [63:0]        rq1_din,
    input  logic [7:0]         rq1_be,
    output logic               rq1_busy,
    output logic [63:0]        rq1_dout,
    output logic               rq1_dout_ready,
    input  logic               ddr_busy,
    output logic [ADDR_W-1:0]  ddr_addr,
    output logic [BURST_W-1:0] ddr_burstcnt,
    output logic               ddr_rd,
    output logic               ddr_we,
    output logic [63:0]        ddr_din,
    output logic [7:0]         ddr_be,
    input  logic [63:0]        ddr_dout,
    input  logic               ddr_dout_ready
);

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    state_t             state, state_next;
    logic               owner, owner_next;
    logic               rr_last, rr_last_next;
    logic [BURST_W-1:0] beats, beats_next;

    logic               req0, req1, grant, sel;
    logic [ADDR_W-1:0]  sel_addr;
    logic [BURST_W-1:0] sel_bc_raw, sel_bc;
    logic               sel_rd, sel_we;
    logic [63:0]        sel_din;
    logic [7:0]         sel_be;

    assign req0 = rq0_rd | rq0_we;
    assign req1 = rq1_rd | rq1_we;

`ifdef JTAGDEMO_DDRARB_FIXEDPRIO_EN
    assign grant = !req0;
`else
    assign grant = (req0 && req1) ? !rr_last : req1;
`endif

    // In IDLE the fresh grant steers the port; once a burst is running the owner does.
    assign sel        = (state == IDLE) ? grant : owner;
    assign sel_addr   = sel ? rq1_addr     : rq0_addr;
    assign sel_bc_raw = sel ? rq1_burstcnt : rq0_burstcnt;
    assign sel_rd     = sel ? rq1_rd       : rq0_rd;
    assign sel_we     = sel ? rq1_we       : rq0_we;
    assign sel_din    = sel ? rq1_din      : rq0_din;
    assign sel_be     = sel ? rq1_be       : rq0_be;
    assign sel_bc     = (sel_bc_raw == '0) ? BURST_W'(1) : sel_bc_raw;

    assign rq0_dout       = ddr_dout;
    assign rq1_dout       = ddr_dout;
    assign rq0_dout_ready = reset_in && (state == READ) && !owner && ddr_dout_ready;
    assign rq1_dout_ready = reset_in && (state == READ) &&  owner && ddr_dout_ready;

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            state   <= IDLE;
            owner   <= 1'b0;
            rr_last <= 1'b1;
            beats   <= '0;
        end else begin
            state   <= state_next;
            owner   <= owner_next;
            rr_last <= rr_last_next;
            beats   <= beats_next;
        end
    end

    always_comb begin
        state_next   = state;
        owner_next   = owner;
        rr_last_next = rr_last;
        beats_next   = beats;
        ddr_addr     = sel_addr;
        ddr_burstcnt = sel_bc;
        ddr_din      = sel_din;
        ddr_be       = sel_be;
        ddr_rd       = 1'b0;
        ddr_we       = 1'b0;
        rq0_busy     = 1'b1;
        rq1_busy     = 1'b1;

        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    // A simultaneous rd+we from one requester is treated as a write.
                    ddr_we   = sel_we;
                    ddr_rd   = sel_rd && !sel_we;
                    rq0_busy = sel ? 1'b1 : ddr_busy;
                    rq1_busy = sel ? ddr_busy : 1'b1;
                    if (!ddr_busy) begin
                        owner_next   = grant;
                        rr_last_next = grant;
                        if (sel_we) begin
                            if (sel_bc != BURST_W'(1)) begin
                                beats_next = sel_bc - BURST_W'(1);
                                state_next = WRITE;
                            end
                        end else begin
                            beats_next = sel_bc;
                            state_next = READ;
                        end
                    end
                end
            end
            WRITE: begin
                ddr_we   = sel_we;
                rq0_busy = sel ? 1'b1 : ddr_busy;
                rq1_busy = sel ? ddr_busy : 1'b1;
                if (sel_we && !ddr_busy) begin
                    beats_next = beats - BURST_W'(1);
                    if (beats == BURST_W'(1)) state_next = IDLE;
                end
            end
            READ: begin
                if (ddr_dout_ready) begin
                    beats_next = beats - BURST_W'(1);
                    if (beats == BURST_W'(1)) state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (!reset_in) begin
            ddr_rd       = 1'b0;
            ddr_we       = 1'b0;
            rq0_busy     = 1'b1;
            rq1_busy     = 1'b1;
            ddr_addr     = '0;
            ddr_burstcnt = '0;
            ddr_din      = '0;
            ddr_be       = '0;
        end
    end

endmodule

// File: tb/tb_ddram_arbiter.sv
// Directed self-checking bench for ddram_arbiter: read/write bursts, tie arbitration, reset.
module tb_ddram_arbiter;

    logic        clk = 1'b0;
    logic        reset_in = 1'b0;
    logic [28:0] rq0_addr = '0, rq1_addr = '0;
    logic [7:0]  rq0_burstcnt = '0, rq1_burstcnt = '0;
    logic        rq0_rd = 1'b0, rq0_we = 1'b0, rq1_rd = 1'b0, rq1_we = 1'b0;
    logic [63:0] rq0_din = '0, rq1_din = '0;
    logic [7:0]  rq0_be = '0, rq1_be = '0;
    logic        rq0_busy, rq1_busy, rq0_dout_ready, rq1_dout_ready;
    logic [63:0] rq0_dout, rq1_dout;
    logic        ddr_busy = 1'b0;
    logic [28:0] ddr_addr;
    logic [7:0]  ddr_burstcnt;
    logic        ddr_rd, ddr_we;
    logic [63:0] ddr_din;
    logic [7:0]  ddr_be;
    logic [63:0] ddr_dout = '0;
    logic        ddr_dout_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ddram_arbiter dut (
        .clk(clk), .reset_in(reset_in),
        .rq0_addr(rq0_addr), .rq0_burstcnt(rq0_burstcnt), .rq0_rd(rq0_rd), .rq0_we(rq0_we),
        .rq0_din(rq0_din), .rq0_be(rq0_be), .rq0_busy(rq0_busy), .rq0_dout(rq0_dout),
        .rq0_dout_ready(rq0_dout_ready),
        .rq1_addr(rq1_addr), .rq1_burstcnt(rq1_burstcnt), .rq1_rd(rq1_rd), .rq1_we(rq1_we),
        .rq1_din(rq1_din), .rq1_be(rq1_be), .rq1_busy(rq1_busy), .rq1_dout(rq1_dout),
        .rq1_dout_ready(rq1_dout_ready),
        .ddr_busy(ddr_busy), .ddr_addr(ddr_addr), .ddr_burstcnt(ddr_burstcnt),
        .ddr_rd(ddr_rd), .ddr_we(ddr_we), .ddr_din(ddr_din), .ddr_be(ddr_be),
        .ddr_dout(ddr_dout), .ddr_dout_ready(ddr_dout_ready)
    );

    task automatic clear_inputs();
        rq0_rd = 0; rq0_we = 0; rq1_rd = 0; rq1_we = 0;
        ddr_busy = 0; ddr_dout_ready = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset_in = 0;
        @(posedge clk); #1;
        reset_in = 1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rq0_rd = 1; rq0_addr = 29'h55; rq1_we = 1; reset_in = 0;
        @(negedge clk);
        checks++; if (ddr_rd !== 1'b0) begin errors++; $display("[TB] FAIL rst_ddr_rd got %0b exp 0", ddr_rd); end
        checks++; if (ddr_we !== 1'b0) begin errors++; $display("[TB] FAIL rst_ddr_we got %0b exp 0", ddr_we); end
        checks++; if ({rq0_busy, rq1_busy} !== 2'b11) begin errors++; $display("[TB] FAIL rst_busy got %b exp 11", {rq0_busy, rq1_busy}); end
        checks++; if (ddr_addr !== 29'h0) begin errors++; $display("[TB] FAIL rst_addr got %h exp 0", ddr_addr); end
        @(posedge clk); #1;
        clear_inputs();
        reset_in = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_read_burst();
        do_reset();
        rq0_rd = 1; rq0_addr = 29'h100; rq0_burstcnt = 8'd4;
        @(negedge clk);
        checks++; if (ddr_rd !== 1'b1) begin errors++; $display("[TB] FAIL rd_issue got %0b exp 1", ddr_rd); end
        checks++; if (ddr_addr !== 29'h100) begin errors++; $display("[TB] FAIL rd_addr got %h exp 100", ddr_addr); end
        checks++; if (ddr_burstcnt !== 8'd4) begin errors++; $display("[TB] FAIL rd_bc got %0d exp 4", ddr_burstcnt); end
        checks++; if (rq0_busy !== 1'b0) begin errors++; $display("[TB] FAIL rd_busy got %0b exp 0", rq0_busy); end
        @(posedge clk); #1;
        rq0_rd = 0;
        for (int i = 0; i < 4; i++) begin
            ddr_dout_ready = 1; ddr_dout = 64'hA000 + 64'(i);
            @(negedge clk);
            checks++; if (rq0_dout_ready !== 1'b1) begin errors++; $display("[TB] FAIL rd_rdy0_%0d got %0b exp 1", i, rq0_dout_ready); end
            checks++; if (rq1_dout_ready !== 1'b0) begin errors++; $display("[TB] FAIL rd_rdy1_%0d got %0b exp 0", i, rq1_dout_ready); end
            checks++; if (rq0_dout !== 64'hA000 + 64'(i)) begin errors++; $display("[TB] FAIL rd_data_%0d got %h exp %h", i, rq0_dout, 64'hA000 + 64'(i)); end
            checks++; if (ddr_rd !== 1'b0) begin errors++; $display("[TB] FAIL rd_hold_%0d got %0b exp 0", i, ddr_rd); end
            @(posedge clk); #1;
        end
        ddr_dout_ready = 0;
        rq0_we = 1; rq0_burstcnt = 8'd1; rq0_din = 64'h77;
        @(negedge clk);
        checks++; if (ddr_we !== 1'b1) begin errors++; $display("[TB] FAIL rd_idle_we got %0b exp 1", ddr_we); end
        checks++; if (rq0_busy !== 1'b0) begin errors++; $display("[TB] FAIL rd_idle_busy got %0b exp 0", rq0_busy); end
        @(posedge clk); #1;
        rq0_we = 0;
    endtask

    task automatic test_tie();
        logic [3:0] exp_grant;
        do_reset();
`ifdef JTAGDEMO_DDRARB_FIXEDPRIO_EN
        exp_grant = 4'b0000;
`else
        exp_grant = 4'b1010;
`endif
        rq0_we = 1; rq0_burstcnt = 8'd1; rq0_din = 64'h1111;
        rq1_we = 1; rq1_burstcnt = 8'd1; rq1_din = 64'h2222;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (rq0_busy !== exp_grant[i]) begin errors++; $display("[TB] FAIL tie_busy0_%0d got %0b exp %0b", i, rq0_busy, exp_grant[i]); end
            checks++; if (rq1_busy !== !exp_grant[i]) begin errors++; $display("[TB] FAIL tie_busy1_%0d got %0b exp %0b", i, rq1_busy, !exp_grant[i]); end
            checks++; if (ddr_din !== (exp_grant[i] ? 64'h2222 : 64'h1111)) begin errors++; $display("[TB] FAIL tie_din_%0d got %h", i, ddr_din); end
            @(posedge clk); #1;
        end
        rq0_we = 0; rq1_we = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_write_burst();
        int accepted;
        logic busy_seq [5] = '{0, 1, 1, 0, 0};
        accepted = 0;
        do_reset();
        rq1_we = 1; rq1_burstcnt = 8'd3; rq1_addr = 29'h200;
        rq0_addr = 29'h300; rq0_burstcnt = 8'd1;
        for (int i = 0; i < 5; i++) begin
            ddr_busy = busy_seq[i];
            rq1_din = 64'hB000 + 64'(i);
            if (i >= 1) rq0_rd = 1;
            @(negedge clk);
            checks++; if (rq1_busy !== busy_seq[i]) begin errors++; $display("[TB] FAIL wr_busy1_%0d got %0b exp %0b", i, rq1_busy, busy_seq[i]); end
            if (i >= 1) begin
                checks++; if (rq0_busy !== 1'b1) begin errors++; $display("[TB] FAIL wr_stall0_%0d got %0b exp 1", i, rq0_busy); end
                checks++; if (ddr_rd !== 1'b0) begin errors++; $display("[TB] FAIL wr_rd_%0d got %0b exp 0", i, ddr_rd); end
            end
            if (ddr_we && !ddr_busy) accepted++;
            @(posedge clk); #1;
        end
        rq1_we = 0; ddr_busy = 0;
        @(negedge clk);
        checks++; if (accepted != 3) begin errors++; $display("[TB] FAIL wr_beats got %0d exp 3", accepted); end
        checks++; if (ddr_rd !== 1'b1 || rq0_busy !== 1'b0) begin errors++; $display("[TB] FAIL wr_next_grant got rd=%0b busy=%0b exp 1/0", ddr_rd, rq0_busy); end
        checks++; if (ddr_addr !== 29'h300) begin errors++; $display("[TB] FAIL wr_next_addr got %h exp 300", ddr_addr); end
        @(posedge clk); #1;
        rq0_rd = 0; ddr_dout_ready = 1;
        @(posedge clk); #1;
        ddr_dout_ready = 0;
    endtask

    task automatic test_burst_zero_and_spurious();
        do_reset();
        rq0_rd = 1; rq0_burstcnt = 8'd0; rq0_addr = 29'h40;
        @(negedge clk);
        checks++; if (ddr_burstcnt !== 8'd1) begin errors++; $display("[TB] FAIL bc0_eff got %0d exp 1", ddr_burstcnt); end
        @(posedge clk); #1;
        rq0_rd = 0; ddr_dout_ready = 1; ddr_dout = 64'hC0DE;
        @(negedge clk);
        checks++; if (rq0_dout_ready !== 1'b1) begin errors++; $display("[TB] FAIL bc0_beat got %0b exp 1", rq0_dout_ready); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if ({rq0_dout_ready, rq1_dout_ready} !== 2'b00) begin errors++; $display("[TB] FAIL spurious_rdy got %b exp 00", {rq0_dout_ready, rq1_dout_ready}); end
        @(posedge clk); #1;
        ddr_dout_ready = 0; rq1_we = 1; rq1_burstcnt = 8'd1;
        @(negedge clk);
        checks++; if (rq1_busy !== 1'b0 || ddr_we !== 1'b1) begin errors++; $display("[TB] FAIL bc0_idle got busy=%0b we=%0b exp 0/1", rq1_busy, ddr_we); end
        @(posedge clk); #1;
        rq1_we = 0;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        rq0_rd = 1; rq0_burstcnt = 8'd8; rq0_addr = 29'h500;
        @(posedge clk); #1;
        rq0_rd = 0;
        for (int i = 0; i < 2; i++) begin
            ddr_dout_ready = 1;
            @(posedge clk); #1;
        end
        rq1_rd = 1; rq1_addr = 29'h600; rq1_burstcnt = 8'd1;
        #2 reset_in = 0;
        #1;
        checks++; if (ddr_rd !== 1'b0 || ddr_we !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_cmd got rd=%0b we=%0b exp 0/0", ddr_rd, ddr_we); end
        checks++; if (rq0_dout_ready !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_rdy got %0b exp 0", rq0_dout_ready); end
        checks++; if ({rq0_busy, rq1_busy} !== 2'b11) begin errors++; $display("[TB] FAIL mid_rst_busy got %b exp 11", {rq0_busy, rq1_busy}); end
        checks++; if (ddr_addr !== 29'h0) begin errors++; $display("[TB] FAIL mid_rst_addr got %h exp 0", ddr_addr); end
        @(posedge clk); #1;
        ddr_dout_ready = 0;
        reset_in = 1;
        @(negedge clk);
        checks++; if (ddr_rd !== 1'b1 || rq1_busy !== 1'b0) begin errors++; $display("[TB] FAIL post_rst_grant got rd=%0b busy=%0b exp 1/0", ddr_rd, rq1_busy); end
        checks++; if (ddr_addr !== 29'h600) begin errors++; $display("[TB] FAIL post_rst_addr got %h exp 600", ddr_addr); end
        @(posedge clk); #1;
        rq1_rd = 0; ddr_dout_ready = 1;
        @(negedge clk);
        checks++; if (rq1_dout_ready !== 1'b1 || rq0_dout_ready !== 1'b0) begin errors++; $display("[TB] FAIL post_rst_beat got %b exp 10", {rq1_dout_ready, rq0_dout_ready}); end
        @(posedge clk); #1;
        ddr_dout_ready = 0;
    endtask

    initial begin
        test_reset();
        test_read_burst();
        test_tie();
        test_write_burst();
        test_burst_zero_and_spurious();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
